// File: rtl/bp_pkg.sv
// Shared types and helpers for the fetch-side branch predictor and the
// execute-side redirect/flush controller.
//   bht_state_e  : 2-bit saturating counter encoding (MSB = predict taken)
//   BR_*         : conditional-branch funct3 codes
//   ctrl_state_e : controller FSM states
//   BHT_RESET    : counter value every table entry takes on reset
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_e;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } ctrl_state_e;

  localparam bht_state_e BHT_RESET = WNT;

  // 010/011 are not branch encodings; such instructions train as not-taken.
  function automatic logic funct3_legal(input logic [2:0] f3);
    logic ok;
    case (f3)
      BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU: ok = 1'b1;
      default:                                          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic bht_state_e sat_update(input bht_state_e ctr, input logic taken);
    bht_state_e nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != ST) nxt = bht_state_e'(ctr + 2'd1);
    end else begin
      if (ctr != SNT) nxt = bht_state_e'(ctr - 2'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predict_ctrl_if.sv
// Execute-stage resolution bus between the branch-resolution logic (master)
// and the redirect/flush controller (slave).
//   e_*          : resolved instruction in E (master -> slave)
//   redirect*    : fetch PC override (slave -> master)
//   flush_d/e    : pipeline squash requests (slave -> master)
interface branch_predict_ctrl_if #(
  parameter int XLEN = 32
);
  logic            e_valid;
  logic [3:0]      e_branch;
  logic            e_jump;
  logic            e_pcsrc;
  logic            e_pred_taken;
  logic [XLEN-1:0] e_pc;
  logic [XLEN-1:0] e_target;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            flush_d;
  logic            flush_e;

  modport master (
    output e_valid, e_branch, e_jump, e_pcsrc, e_pred_taken, e_pc, e_target,
    input  redirect, redirect_pc, flush_d, flush_e
  );

  modport slave (
    input  e_valid, e_branch, e_jump, e_pcsrc, e_pred_taken, e_pc, e_target,
    output redirect, redirect_pc, flush_d, flush_e
  );
endinterface

// File: rtl/bht_counter_array.sv
// Branch history table: ENTRIES x 2-bit saturating counters.
//   clk, rst_n : clock, async active-low reset (all entries -> BHT_RESET)
//   rd_idx     : async read index, rd_ctr returns the stored counter
//   wr_en      : update strobe, wr_idx entry moves toward wr_taken
// A read of the entry being updated returns the pre-update value.
module bht_counter_array
  import bp_pkg::*;
#(
  parameter  int ENTRIES = 64,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output bht_state_e       rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  bht_state_e table_q [ENTRIES];

  assign rd_ctr = table_q[rd_idx];

  // NOTE: every entry is reset, not just the state machine -- a stale
  // counter after reset would make the first predictions depend on
  // whatever ran before, so the table is flops with async reset, not SRAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= BHT_RESET;
    end else if (wr_en) begin
      table_q[wr_idx] <= sat_update(table_q[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Fetch-side branch predictor plus execute-side redirect/flush controller.
//   clk, rst_n          : clock, async active-low reset
//   stall               : freezes table updates, counters and redirect
//   f_pc/f_is_branch/f_target -> f_pred_taken, f_pred_pc : F-stage prediction
//   ex (slave)          : E-stage resolution in, redirect/flush out
//   n_branches          : resolved conditional branches (saturating)
//   n_mispredicts       : redirects due to wrong prediction or jump
module branch_predict_ctrl
  import bp_pkg::*;
#(
  parameter  int ENTRIES = 64,
  parameter  int XLEN    = 32,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic [XLEN-1:0]       f_pc,
  input  logic                  f_is_branch,
  input  logic [XLEN-1:0]       f_target,
  output logic                  f_pred_taken,
  output logic [XLEN-1:0]       f_pred_pc,
  branch_predict_ctrl_if.slave  ex,
  output logic [31:0]           n_branches,
  output logic [31:0]           n_mispredicts
);

  ctrl_state_e      state;
  bht_state_e       f_ctr;
  logic [IDX_W-1:0] f_idx;
  logic [IDX_W-1:0] e_idx;
  logic             is_br;
  logic             br_taken;
  logic             res;
  logic             mispredict;

  assign f_idx = f_pc[IDX_W+1:2];
  assign e_idx = ex.e_pc[IDX_W+1:2];

  bht_counter_array #(.ENTRIES(ENTRIES)) u_bht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (f_idx),
    .rd_ctr   (f_ctr),
    .wr_en    (res & is_br),
    .wr_idx   (e_idx),
    .wr_taken (br_taken)
  );

  // Fetch prediction: jumps are never predicted, only predecoded branches.
  assign f_pred_taken = f_is_branch & f_ctr[1];
  assign f_pred_pc    = f_pred_taken ? f_target : f_pc + XLEN'(4);

  assign is_br    = ex.e_branch[3];
  assign br_taken = ex.e_pcsrc & funct3_legal(ex.e_branch[2:0]);

  // Gated by rst_n so a live E instruction cannot redirect while in reset.
  // In RECOVER the E slot holds the squashed instruction and must be ignored.
  assign res        = rst_n & ex.e_valid & ~stall & (state == RUN);
  assign mispredict = res & (is_br | ex.e_jump) & (ex.e_pcsrc != ex.e_pred_taken);

  assign ex.redirect    = mispredict;
  assign ex.flush_d     = mispredict;
  assign ex.flush_e     = mispredict;
  assign ex.redirect_pc = ex.e_pcsrc ? ex.e_target : ex.e_pc + XLEN'(4);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (mispredict) state <= RECOVER;
        RECOVER: if (!stall)     state <= RUN;
        default:                 state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_branches    <= '0;
      n_mispredicts <= '0;
    end else begin
      if (res && is_br && n_branches != 32'hFFFF_FFFF)
        n_branches <= n_branches + 32'd1;
      if (mispredict && n_mispredicts != 32'hFFFF_FFFF)
        n_mispredicts <= n_mispredicts + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
module tb_branch_predict_ctrl;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic [31:0] f_pc;
  logic        f_is_branch;
  logic [31:0] f_target;
  logic        f_pred_taken;
  logic [31:0] f_pred_pc;
  logic [31:0] n_branches;
  logic [31:0] n_mispredicts;

  branch_predict_ctrl_if #(.XLEN(32)) ex_if ();

  branch_predict_ctrl #(.ENTRIES(64), .XLEN(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .f_pc          (f_pc),
    .f_is_branch   (f_is_branch),
    .f_target      (f_target),
    .f_pred_taken  (f_pred_taken),
    .f_pred_pc     (f_pred_pc),
    .ex            (ex_if.slave),
    .n_branches    (n_branches),
    .n_mispredicts (n_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  typedef struct {
    logic        stall;
    logic [31:0] f_pc;
    logic        f_br;
    logic [31:0] f_tgt;
    logic        ev;
    logic [3:0]  ebr;
    logic        ej;
    logic        epcsrc;
    logic        epred;
    logic [31:0] epc;
    logic [31:0] etgt;
    logic        x_pt;
    logic [31:0] x_ppc;
    logic        x_redir;
    logic [31:0] x_rpc;
    logic [31:0] x_nb;
    logic [31:0] x_nm;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic drive_e(input logic ev, input logic [3:0] ebr, input logic ej,
                         input logic pcsrc, input logic pred,
                         input logic [31:0] epc, input logic [31:0] etgt);
    ex_if.e_valid      = ev;
    ex_if.e_branch     = ebr;
    ex_if.e_jump       = ej;
    ex_if.e_pcsrc      = pcsrc;
    ex_if.e_pred_taken = pred;
    ex_if.e_pc         = epc;
    ex_if.e_target     = etgt;
  endtask

  task automatic drive_f(input logic [31:0] pc, input logic br, input logic [31:0] tgt);
    f_pc        = pc;
    f_is_branch = br;
    f_target    = tgt;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_redir(input string tag, input logic exp, input logic [31:0] exp_pc);
    check({tag, "_redirect"}, {31'd0, ex_if.redirect}, {31'd0, exp});
    check({tag, "_flush_d"},  {31'd0, ex_if.flush_d},  {31'd0, exp});
    check({tag, "_flush_e"},  {31'd0, ex_if.flush_e},  {31'd0, exp});
    if (exp) check({tag, "_redirect_pc"}, ex_if.redirect_pc, exp_pc);
  endtask

  task automatic check_pred(input string tag, input logic pt, input logic [31:0] ppc);
    check({tag, "_pred_taken"}, {31'd0, f_pred_taken}, {31'd0, pt});
    check({tag, "_pred_pc"}, f_pred_pc, ppc);
  endtask

  task automatic check_cnt(input string tag, input logic [31:0] nb, input logic [31:0] nm);
    check({tag, "_n_branches"}, n_branches, nb);
    check({tag, "_n_mispredicts"}, n_mispredicts, nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // stall  f_pc          f_br f_tgt        ev ebr      ej pcs prd e_pc          e_tgt         pt ppc           rd rpc           nb  nm
    vecs[0]  = '{1'b0, 32'h100, 1'b1, 32'h140, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,     1'b0, 32'h104, 1'b0, 32'h0,   32'd0, 32'd0};
    vecs[1]  = '{1'b0, 32'h100, 1'b1, 32'h140, 1'b1, 4'b1000, 1'b0, 1'b1, 1'b0, 32'h100, 32'h140, 1'b0, 32'h104, 1'b1, 32'h140, 32'd1, 32'd1};
    vecs[2]  = '{1'b0, 32'h100, 1'b1, 32'h140, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,     1'b1, 32'h140, 1'b0, 32'h0,   32'd1, 32'd1};
    vecs[3]  = '{1'b0, 32'h100, 1'b1, 32'h140, 1'b1, 4'b1000, 1'b0, 1'b1, 1'b0, 32'h100, 32'h140, 1'b1, 32'h140, 1'b1, 32'h140, 32'd2, 32'd2};
    vecs[4]  = '{1'b0, 32'h100, 1'b1, 32'h140, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,     1'b1, 32'h140, 1'b0, 32'h0,   32'd2, 32'd2};
    vecs[5]  = '{1'b0, 32'h100, 1'b1, 32'h140, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b1, 32'h100, 32'h140, 1'b1, 32'h140, 1'b1, 32'h104, 32'd3, 32'd3};
    vecs[6]  = '{1'b0, 32'h100, 1'b1, 32'h140, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,     1'b1, 32'h140, 1'b0, 32'h0,   32'd3, 32'd3};
    vecs[7]  = '{1'b0, 32'h100, 1'b1, 32'h140, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 32'h200, 32'h300, 1'b1, 32'h140, 1'b1, 32'h300, 32'd3, 32'd4};
    vecs[8]  = '{1'b0, 32'h100, 1'b1, 32'h140, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,     1'b1, 32'h140, 1'b0, 32'h0,   32'd3, 32'd4};
    vecs[9]  = '{1'b0, 32'h104, 1'b1, 32'h180, 1'b1, 4'b1001, 1'b0, 1'b1, 1'b1, 32'h104, 32'h180, 1'b0, 32'h108, 1'b0, 32'h0,   32'd4, 32'd4};
    vecs[10] = '{1'b0, 32'h104, 1'b1, 32'h180, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,     1'b1, 32'h180, 1'b0, 32'h0,   32'd4, 32'd4};
    vecs[11] = '{1'b0, 32'h104, 1'b1, 32'h180, 1'b1, 4'b1010, 1'b0, 1'b0, 1'b1, 32'h104, 32'h180, 1'b1, 32'h180, 1'b1, 32'h108, 32'd5, 32'd5};
    vecs[12] = '{1'b0, 32'h104, 1'b1, 32'h180, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,     1'b0, 32'h108, 1'b0, 32'h0,   32'd5, 32'd5};
    vecs[13] = '{1'b0, 32'h100, 1'b0, 32'h140, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,     1'b0, 32'h104, 1'b0, 32'h0,   32'd5, 32'd5};
    vecs[14] = '{1'b1, 32'h100, 1'b1, 32'h140, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b1, 32'h100, 32'h140, 1'b1, 32'h140, 1'b0, 32'h0,   32'd5, 32'd5};
    vecs[15] = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 4'b1000, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h40, 1'b0, 32'h4, 1'b1, 32'h0, 32'd6, 32'd6};
    vecs[16] = '{1'b0, 32'hFFFF_FFFC, 1'b1, 32'h40, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,   1'b0, 32'h0,   32'd6, 32'd6};

    rst_n = 1'b0;
    stall = 1'b0;
    drive_f(32'h100, 1'b1, 32'h140);
    drive_e(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_cnt("reset", 32'd0, 32'd0);
    check_redir("reset", 1'b0, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      string tag;
      tag   = $sformatf("vec%0d", i);
      stall = vecs[i].stall;
      drive_f(vecs[i].f_pc, vecs[i].f_br, vecs[i].f_tgt);
      drive_e(vecs[i].ev, vecs[i].ebr, vecs[i].ej, vecs[i].epcsrc, vecs[i].epred,
              vecs[i].epc, vecs[i].etgt);
      #1;
      check_pred(tag, vecs[i].x_pt, vecs[i].x_ppc);
      check_redir(tag, vecs[i].x_redir, vecs[i].x_rpc);
      edge_step();
      check_cnt(tag, vecs[i].x_nb, vecs[i].x_nm);
    end

    // Mispredict immediately followed by a valid branch in E: ignored in RECOVER.
    stall = 1'b0;
    drive_f(32'h100, 1'b1, 32'h140);
    drive_e(1'b1, 4'b1000, 1'b0, 1'b0, 1'b1, 32'h100, 32'h140);
    #1;
    check_redir("rec_first", 1'b1, 32'h104);
    edge_step();
    check_cnt("rec_first", 32'd7, 32'd7);
    check_redir("rec_slot", 1'b0, 32'h0);
    edge_step();
    check_cnt("rec_slot", 32'd7, 32'd7);
    check_pred("rec_slot", 1'b0, 32'h104);
    drive_e(1'b1, 4'b1000, 1'b0, 1'b1, 1'b0, 32'h100, 32'h140);
    #1;
    check_redir("rec_next", 1'b1, 32'h140);
    edge_step();
    check_cnt("rec_next", 32'd8, 32'd8);
    drive_e(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    edge_step();
    check_pred("rec_next", 1'b1, 32'h140);

    // Stalled mispredicting branch: frozen for 3 cycles, then exactly one resolve.
    stall = 1'b1;
    drive_e(1'b1, 4'b1000, 1'b0, 1'b0, 1'b1, 32'h100, 32'h140);
    for (int c = 0; c < 3; c++) begin
      string tag;
      tag = $sformatf("stall%0d", c);
      #1;
      check_redir(tag, 1'b0, 32'h0);
      edge_step();
      check_cnt(tag, 32'd8, 32'd8);
      check_pred(tag, 1'b1, 32'h140);
    end
    stall = 1'b0;
    #1;
    check_redir("unstall", 1'b1, 32'h104);
    edge_step();
    check_cnt("unstall", 32'd9, 32'd9);
    check_pred("unstall", 1'b0, 32'h104);

    // Reset asserted mid-cycle while in RECOVER with a mispredicting E instr.
    rst_n = 1'b0;
    #1;
    check_redir("rst_rec", 1'b0, 32'h0);
    check_cnt("rst_rec", 32'd0, 32'd0);
    check_pred("rst_rec", 1'b0, 32'h104);
    rst_n = 1'b1;
    #1;
    check_redir("post_rst", 1'b1, 32'h104);
    edge_step();
    check_cnt("post_rst", 32'd1, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
- Fetch-side branch predictor and execute-side redirect/flush controller for the pipelined core.
- Predicts conditional branches in F from a table of 2-bit saturating counters.
- Compares the actual outcome (execute-stage PC-select decision) against the prediction carried down the pipe. Drives PC redirect, D/E flushes and performance counters.
- Sits between the fetch PC mux, the pipeline registers and the execute-stage branch-resolution logic.

Parameters:
ENTRIES, 64, number of counter-table entries (power of two, >=4)
IDX_W, $clog2(ENTRIES), table index width (derived, not overridden)
XLEN, 32, PC/address width

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
stall  in  1  pipeline stall; freezes updates and redirect
f_pc  in  XLEN  fetch PC
f_is_branch  in  1  predecode: fetched instr is conditional branch
f_target  in  XLEN  predecoded branch target (pc+imm)
f_pred_taken  out  1  prediction, carried to E by pipeline regs
f_pred_pc  out  XLEN  predicted next fetch PC
e_valid  in  1  E stage holds a real (non-bubble) instr
e_branch  in  4  execute branch code: bit3=branch, [2:0]=funct3
e_jump  in  1  E instr is jal/jalr
e_pcsrc  in  1  actual taken decision from E resolution
e_pred_taken  in  1  prediction that travelled with E instr
e_pc  in  XLEN  PC of E instr
e_target  in  XLEN  resolved target of E instr
redirect  out  1  override fetch PC this cycle
redirect_pc  out  XLEN  corrected PC
flush_d  out  1  squash D stage
flush_e  out  1  squash E stage at next edge
n_branches  out  32  resolved conditional branches
n_mispredicts  out  32  redirects caused by wrong prediction/jump

Behaviour:
- Index idx = f_pc[IDX_W+1:2]; E update index = e_pc[IDX_W+1:2].
- F, combinational: f_pred_taken = f_is_branch & bht[idx][1]. f_pred_pc = f_pred_taken ? f_target : f_pc+4. Jumps never predicted (f_pred_taken=0).
- Resolve qualifier res = e_valid & ~stall & (state==RUN).
- is_br = e_branch[3]. Funct3 010/011 are illegal: e_pcsrc is 0 for them, and they count and train as not-taken.
- mispredict = res & (is_br | e_jump) & (e_pcsrc != e_pred_taken). An unpredicted taken jump is a mispredict.
- Same cycle as mispredict: redirect=flush_d=flush_e=1. redirect_pc = e_pcsrc ? e_target : e_pc+4 (mod 2^XLEN, wraps).
- All other times redirect, flush_d and flush_e are 0, including whenever stall=1.
- Table update at posedge when res & is_br: taken -> min(ctr+1,3); not-taken -> max(ctr-1,0).
- No update for jumps, bubbles or while stall=1.
- Read/write same index in same cycle: F sees the pre-update value.
- FSM states:
  - RUN -> RECOVER on mispredict.
  - RECOVER -> RUN after exactly one unstalled cycle; stays in RECOVER while stall=1.
  - In RECOVER, E holds a flushed slot. res is forced 0: no update, no count, no redirect.
- Perf counters at posedge:
  - n_branches += 1 when res & is_br.
  - n_mispredicts += 1 on mispredict.
  - Both saturate at 32'hFFFF_FFFF.
- Reset (async, any time, including mid-recovery): every table entry = 2'b01 (weakly not-taken), state=RUN, counters=0. Outputs redirect/flush_*=0, f_pred_taken=0 unless a predecoded branch hits an entry that reset sets strongly taken (none do). Operation resumes on the first edge after rst_n rises.

Decomposition:
- Shared package bp_pkg:
  - bht_state_e (SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11)
  - BR_* funct3 constants (BEQ=000, BNE=001, BLT=100, BGE=101, BLTU=110, BGEU=111)
  - ctrl_state_e (RUN, RECOVER)
  - BHT_RESET = WNT
- One sub-module, bht_counter_array: ENTRIES x 2-bit table with one async read port, one sync saturating-update port and async reset. The controller FSM, redirect and counters stay in branch_predict_ctrl.

Test Plan:
- Reset, then f_pc=0x100, f_is_branch=1, f_target=0x140 -> f_pred_taken=0, f_pred_pc=0x104. Counters read 0.
- Resolve beq at e_pc=0x100 taken twice, e_pred_taken=0 each time, with an unstalled non-E cycle between -> first resolve redirect=1, redirect_pc=e_target, flush_d=flush_e=1. Next F of 0x100 predicts taken, f_pred_pc=0x140. n_mispredicts=2.
- Train entry to ST (3 taken), then resolve not-taken with e_pred_taken=1 -> redirect_pc=e_pc+4, entry becomes WT, prediction still taken.
- Mispredict followed immediately by e_valid=1 branch in E next cycle -> no second redirect, no table/counter change (RECOVER). Branch one cycle later resolves normally.
- stall=1 with a mispredicting branch in E for 3 cycles -> redirect=0 and no updates throughout. On stall drop, exactly one redirect, one n_branches increment, one table update.
- Taken jal (e_jump=1, e_pcsrc=1, e_pred_taken=0) -> redirect to e_target, n_mispredicts+1, n_branches unchanged. Also: assert rst_n=0 during RECOVER -> all outputs 0 immediately, state RUN.
